// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int unsigned NM    = 2;
    localparam logic        M_CPU = 1'b0;
    localparam logic        M_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick2.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [NM-1:0] req,
    input  logic          last,
    output logic [NM-1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M_LDR) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU data port and a loader/debug port onto one single-port
// data memory, with round-robin fairness and per-master bus locking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NM-1:0] m_req,
    input  logic [NM-1:0] m_we,
    input  logic [NM-1:0] m_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic [NM-1:0] m_gnt,
    output logic [NM-1:0] m_rvalid,
    output logic [DW-1:0] m_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [NM-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [NM-1:0] pick_gnt;
    logic [NM-1:0] gnt_c;
    logic [NM-1:0] gnt;
    logic [NM-1:0] rd_gnt;

    rr_pick2 u_pick (
        .req  (m_req),
        .last (rr_last_q),
        .gnt  (pick_gnt)
    );

    // Grant selection and lock tracking; a lock holder keeps the bus only while requesting.
    always_comb begin
        gnt_c   = '0;
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                gnt_c = pick_gnt;
                if (pick_gnt[M_CPU] && m_lock[M_CPU]) begin
                    state_d = LOCK0;
                end else if (pick_gnt[M_LDR] && m_lock[M_LDR]) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                gnt_c[M_CPU] = m_req[M_CPU];
                if (!m_req[M_CPU] || !m_lock[M_CPU]) state_d = ARB;
            end
            default: begin
                gnt_c[M_LDR] = m_req[M_LDR];
                if (!m_req[M_LDR] || !m_lock[M_LDR]) state_d = ARB;
            end
        endcase
    end

    // Reset kills the grant immediately, not just at the next edge.
    assign gnt    = rst ? '0 : gnt_c;
    assign m_gnt  = gnt;
    assign rd_gnt = gnt & ~m_we;

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[M_CPU]) begin
            mem_wen   = m_we[M_CPU];
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt[M_LDR]) begin
            mem_wen   = m_we[M_LDR];
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (|gnt) rr_last_d = gnt[M_LDR];
        rvalid_d = rd_gnt;
        rdata_d  = (|rd_gnt) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            rr_last_q <= M_LDR;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, round-robin writes, locking and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_we, m_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [1:0]  m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_lock    (m_lock),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m_req = 2'b00; m_we = 2'b00; m_lock = 2'b00;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; mem_rdata = '0;

        // Reset values, and grant suppressed while reset is held
        #2;
        m_req = 2'b01;
        #1;
        chk("rst_gnt",    64'(m_gnt),    64'h0);
        chk("rst_rvalid", 64'(m_rvalid), 64'h0);
        chk("rst_rdata",  64'(m_rdata),  64'h0);
        chk("rst_wen",    64'(mem_wen),  64'h0);
        chk("rst_addr",   64'(mem_addr), 64'h0);
        m_req = 2'b00;
        tick();
        rst = 1'b0;

        // CPU single read
        m_req = 2'b01; m_we = 2'b00; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_gnt",  64'(m_gnt),    64'h1);
        chk("rd_addr", 64'(mem_addr), 64'h10);
        chk("rd_wen",  64'(mem_wen),  64'h0);
        tick();
        m_req = 2'b00; mem_rdata = 32'h12345678;
        #1;
        chk("rd_rvalid", 64'(m_rvalid), 64'h1);
        chk("rd_rdata",  64'(m_rdata),  64'hDEADBEEF);
        chk("idle_gnt",  64'(m_gnt),    64'h0);
        chk("idle_addr", 64'(mem_addr), 64'h0);
        tick();
        chk("rd_pulse_end", 64'(m_rvalid), 64'h0);
        chk("rd_hold",      64'(m_rdata),  64'hDEADBEEF);

        // Both masters write after a fresh reset: alternate starting with CPU
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        m_req = 2'b11; m_we = 2'b11; m0_addr = 32'h100; m1_addr = 32'h200;
        m0_wdata = 32'hAAAA0000; m1_wdata = 32'hBBBB1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt",    64'(m_gnt),    (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_wen",    64'(mem_wen),  64'h1);
            chk("rr_addr",   64'(mem_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
            chk("rr_wdata",  64'(mem_wdata), (i % 2 == 0) ? 64'hAAAA0000 : 64'hBBBB1111);
            chk("rr_rvalid", 64'(m_rvalid), 64'h0);
            tick();
        end
        m_req = 2'b00;
        #1;
        chk("rr_rvalid_after", 64'(m_rvalid), 64'h0);

        // Back-to-back reads from different masters
        m_req = 2'b01; m_we = 2'b00; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("b2b_gnt0", 64'(m_gnt), 64'h1);
        tick();
        m_req = 2'b10; mem_rdata = 32'h0BADF00D;
        #1;
        chk("b2b_gnt1",    64'(m_gnt),    64'h2);
        chk("b2b_rvalid0", 64'(m_rvalid), 64'h1);
        chk("b2b_rdata0",  64'(m_rdata),  64'hCAFEF00D);
        tick();
        m_req = 2'b01; m_we = 2'b01; mem_rdata = 32'h99999999;
        #1;
        chk("b2b_rvalid1", 64'(m_rvalid), 64'h2);
        chk("b2b_rdata1",  64'(m_rdata),  64'h0BADF00D);
        chk("wr_gnt",      64'(m_gnt),    64'h1);
        tick();
        m_req = 2'b00;
        #1;
        chk("wr_no_rvalid", 64'(m_rvalid), 64'h0);
        chk("wr_rdata_hold", 64'(m_rdata), 64'h0BADF00D);

        // Loader lock (rr_last = CPU, so loader wins the tie)
        m_req = 2'b11; m_we = 2'b11; m_lock = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lk1_gnt", 64'(m_gnt), 64'h2);
            tick();
        end
        m_lock = 2'b00;
        #1;
        chk("lk1_release_gnt", 64'(m_gnt), 64'h2);
        tick();
        chk("lk1_cpu_after", 64'(m_gnt), 64'h1);
        tick();
        m_req = 2'b00;
        tick();

        // Both lock with rr_last = CPU: loader enters LOCK1, CPU waits
        m_req = 2'b11; m_lock = 2'b11;
        #1;
        chk("dlk_gnt0", 64'(m_gnt), 64'h2);
        tick();
        chk("dlk_gnt1", 64'(m_gnt), 64'h2);
        tick();
        chk("dlk_gnt2", 64'(m_gnt), 64'h2);
        m_req = 2'b01;
        #1;
        chk("dlk_cpu_wait", 64'(m_gnt), 64'h0);
        tick();
        chk("dlk_cpu_gnt", 64'(m_gnt), 64'h1);
        m_req = 2'b00; m_lock = 2'b00;
        tick();

        // Reset asserted in the middle of a granted read
        m_req = 2'b01; m_we = 2'b00; m0_addr = 32'h40; mem_rdata = 32'h55AA55AA;
        #1;
        chk("mr_gnt_pre", 64'(m_gnt), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_gnt",    64'(m_gnt),    64'h0);
        chk("mr_rvalid", 64'(m_rvalid), 64'h0);
        chk("mr_wen",    64'(mem_wen),  64'h0);
        chk("mr_addr",   64'(mem_addr), 64'h0);
        m_req = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        chk("mr_no_rvalid", 64'(m_rvalid), 64'h0);
        chk("mr_rdata",     64'(m_rdata),  64'h0);
        m_req = 2'b11; m_we = 2'b11;
        #1;
        chk("mr_first_tie", 64'(m_gnt), 64'h1);
        tick();
        m_req = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, SHALL set the address width.
REQ-002 Parameter DW, default 32, SHALL set the data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 m_req  in  2  SHALL be the per-master request (bit0 = CPU data port, bit1 = loader/debug port).
REQ-006 m_we  in  2  SHALL be the per-master write enable, valid with m_req.
REQ-007 m_lock  in  2  SHALL be the per-master bus-hold request, valid with m_req.
REQ-008 m0_addr, m1_addr  in  AW each  SHALL be the per-master byte addresses.
REQ-009 m0_wdata, m1_wdata  in  DW each  SHALL be the per-master write data.
REQ-010 m_gnt  out  2  SHALL be the one-hot (or zero) grant, combinational in the access cycle.
REQ-011 m_rvalid  out  2  SHALL be the per-master read-data-valid strobe, one cycle after a granted read.
REQ-012 m_rdata  out  DW  SHALL be the registered read data, shared by both masters and qualified by m_rvalid.
REQ-013 mem_wen  out  1, mem_addr  out  AW, mem_wdata  out  DW  SHALL drive the single-port data memory.
REQ-014 mem_rdata  in  DW  SHALL be the data memory's combinational read data.

Function
REQ-015 The block SHALL grant at most one master per cycle; one grant = one memory access in that cycle.
REQ-016 The memory-side outputs SHALL mux the granted master's we/addr/wdata; with no grant, mem_wen SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-017 FSM states SHALL be ARB, LOCK0 and LOCK1.
REQ-018 In ARB with a single requester, that requester SHALL be granted.
REQ-019 In ARB with both requesting, the master not granted most recently (rr_last pointer) SHALL be granted.
REQ-020 rr_last SHALL update to the granted index on every grant and SHALL hold otherwise.
REQ-021 ARB->LOCKn SHALL occur when master n is granted with m_lock[n]=1.
REQ-022 In LOCKn, only master n SHALL be granted, and only while m_req[n]=1; other requests SHALL wait with gnt=0.
REQ-023 LOCKn->ARB SHALL occur at the end of any cycle in which m_req[n]=0 or m_lock[n]=0; that cycle's access SHALL still be granted if m_req[n]=1.
REQ-024 For a granted read (we=0), mem_rdata SHALL be registered into m_rdata, and m_rvalid[n] SHALL pulse high for exactly one cycle on the next cycle.
REQ-025 A granted write SHALL produce no m_rvalid pulse; m_rdata SHALL hold its last value.
REQ-026 Back-to-back reads SHALL be sustained at one per cycle; each read's rvalid SHALL be independent of the following cycle's grant.
REQ-027 A request dropped before grant SHALL have no effect; requesters SHALL hold req/we/addr/wdata stable until granted.
REQ-028 Simultaneous lock requests in ARB SHALL be resolved by the round-robin rule; the loser SHALL wait.

Reset
REQ-029 On rst assertion, outputs SHALL immediately become: state=ARB, rr_last=1 (CPU wins the first tie), m_gnt=0, m_rvalid=0, m_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-030 A read granted in the cycle rst asserts SHALL produce no rvalid after reset release.
REQ-031 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-032 A shared package mem_arb_pkg SHALL hold the state enum (ARB, LOCK0, LOCK1) and the master index constants (M_CPU=0, M_LDR=1).
REQ-033 One sub-module, rr_pick2 (two-way round-robin picker: req, last -> one-hot gnt), SHALL be used; everything else SHALL be in mem_arbiter.

Verification
REQ-034 CPU read only: m_req=01, m0_addr=0x10, mem_rdata=0xDEADBEEF -> m_gnt=01 same cycle; next cycle m_rvalid=01, m_rdata=0xDEADBEEF.
REQ-035 Both request writes for 4 cycles after reset -> grants alternate 01,10,01,10; mem_wen=1 every cycle; m_rvalid stays 00.
REQ-036 Loader lock: m_req=11, m_lock=10, loader wins, holds 3 cycles -> m_gnt=10 throughout; CPU granted on the cycle after m_lock[1] drops.
REQ-037 Both lock in ARB with rr_last=0 -> loader enters LOCK1; CPU gnt=0 until the loader releases.
REQ-038 rst asserted mid-read (gnt=01) -> m_gnt, m_rvalid and mem_wen go to 0 asynchronously; no rvalid after release; the first post-reset tie goes to the CPU.
